// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe_if
// Brief    : Handshake/data bundle between decode, imm_gen_pipe and execute.
// Revision : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            Flush;
    logic            InValid;
    logic            InReady;
    logic [31:0]     Instr;
    logic [2:0]      ImmSrc;
    logic            OutValid;
    logic            OutReady;
    logic [XLEN-1:0] ImmExt;
    logic [31:0]     InstrOut;
    logic            IllegalImm;
    logic [1:0]      Count;

    // master: the surroundings (decode upstream, execute downstream)
    modport master (
        output Flush, InValid, Instr, ImmSrc, OutReady,
        input  InReady, OutValid, ImmExt, InstrOut, IllegalImm, Count
    );

    // slave: the immediate generator itself
    modport slave (
        input  Flush, InValid, Instr, ImmSrc, OutReady,
        output InReady, OutValid, ImmExt, InstrOut, IllegalImm, Count
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : RV32I immediate generator with a two-entry valid/ready skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_pipe_if.slave  bus
);

    localparam logic [2:0] c_FMT_I    = 3'b000;
    localparam logic [2:0] c_FMT_S    = 3'b001;
    localparam logic [2:0] c_FMT_B    = 3'b010;
    localparam logic [2:0] c_FMT_U    = 3'b011;
    localparam logic [2:0] c_FMT_J    = 3'b100;
    localparam logic [2:0] c_FMT_ZIMM = 3'b101;

    logic            w_s;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_ill;
    logic            w_accept;
    logic            w_pop;

    logic            r_main_v;
    logic [XLEN-1:0] r_main_imm;
    logic [31:0]     r_main_instr;
    logic            r_main_ill;
    logic            r_skid_v;
    logic [XLEN-1:0] r_skid_imm;
    logic [31:0]     r_skid_instr;
    logic            r_skid_ill;

    assign w_s = bus.Instr[31];

    // Build a 32-bit value whose bit 31 already equals the wanted fill bit,
    // then sign-extend once to XLEN (zimm has bit 31 clear, so it zero-fills).
    always_comb begin
        w_imm32 = {{20{w_s}}, bus.Instr[31:20]};
        w_ill   = 1'b0;
        case (bus.ImmSrc)
            c_FMT_I:    w_imm32 = {{20{w_s}}, bus.Instr[31:20]};
            c_FMT_S:    w_imm32 = {{20{w_s}}, bus.Instr[31:25], bus.Instr[11:7]};
            c_FMT_B:    w_imm32 = {{20{w_s}}, bus.Instr[7], bus.Instr[30:25],
                                   bus.Instr[11:8], 1'b0};
            c_FMT_U:    w_imm32 = {bus.Instr[31:12], 12'b0};
            c_FMT_J:    w_imm32 = {{12{w_s}}, bus.Instr[19:12], bus.Instr[20],
                                   bus.Instr[30:21], 1'b0};
            c_FMT_ZIMM: w_imm32 = {27'b0, bus.Instr[19:15]};
            default:    w_ill   = 1'b1;
        endcase
    end

    assign w_imm    = XLEN'($signed(w_imm32));

    // InReady depends only on state, so no combinational path from OutReady.
    assign w_accept = bus.InValid & ~r_skid_v & ~bus.Flush;
    assign w_pop    = r_main_v & bus.OutReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_v     <= 1'b0;
            r_main_imm   <= '0;
            r_main_instr <= '0;
            r_main_ill   <= 1'b0;
            r_skid_v     <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_instr <= '0;
            r_skid_ill   <= 1'b0;
        end else if (bus.Flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else begin
            case ({w_accept, w_pop})
                2'b10: begin
                    if (!r_main_v) begin
                        r_main_v     <= 1'b1;
                        r_main_imm   <= w_imm;
                        r_main_instr <= bus.Instr;
                        r_main_ill   <= w_ill;
                    end else begin
                        r_skid_v     <= 1'b1;
                        r_skid_imm   <= w_imm;
                        r_skid_instr <= bus.Instr;
                        r_skid_ill   <= w_ill;
                    end
                end
                2'b01: begin
                    if (r_skid_v) begin
                        r_main_imm   <= r_skid_imm;
                        r_main_instr <= r_skid_instr;
                        r_main_ill   <= r_skid_ill;
                        r_skid_v     <= 1'b0;
                    end else begin
                        r_main_v     <= 1'b0;
                    end
                end
                2'b11: begin
                    if (r_skid_v) begin
                        r_main_imm   <= r_skid_imm;
                        r_main_instr <= r_skid_instr;
                        r_main_ill   <= r_skid_ill;
                        r_skid_imm   <= w_imm;
                        r_skid_instr <= bus.Instr;
                        r_skid_ill   <= w_ill;
                    end else begin
                        r_main_imm   <= w_imm;
                        r_main_instr <= bus.Instr;
                        r_main_ill   <= w_ill;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.InReady    = ~r_skid_v;
    assign bus.OutValid   = r_main_v;
    assign bus.ImmExt     = r_main_imm;
    assign bus.InstrOut   = r_main_instr;
    assign bus.IllegalImm = r_main_ill;
    assign bus.Count      = {1'b0, r_main_v} + {1'b0, r_skid_v};

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Scoreboard bench for imm_gen_pipe at XLEN=32 and XLEN=64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [31:0] instr;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t q32[$];
    exp_t q64[$];

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    imm_gen_pipe #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_gen_pipe #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: a beat is delivered only on a non-flushed valid&ready cycle.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst_n && b32.OutValid && b32.OutReady && !b32.Flush) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out32_unexpected: got instr %h expected none", b32.InstrOut);
            end else begin
                e = q32.pop_front();
                chk("imm32",   {32'h0, b32.ImmExt}, e.imm);
                chk("instr32", {32'h0, b32.InstrOut}, {32'h0, e.instr});
                chk("ill32",   {63'h0, b32.IllegalImm}, {63'h0, e.ill});
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (rst_n && b64.OutValid && b64.OutReady && !b64.Flush) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out64_unexpected: got instr %h expected none", b64.InstrOut);
            end else begin
                e = q64.pop_front();
                chk("imm64",   b64.ImmExt, e.imm);
                chk("instr64", {32'h0, b64.InstrOut}, {32'h0, e.instr});
            end
        end
    end

    task automatic send32(input logic [31:0] ins, input logic [2:0] src,
                          input logic [31:0] imm, input logic ill);
        bit rdy;
        int n;
        b32.Instr   = ins;
        b32.ImmSrc  = src;
        b32.InValid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = b32.InReady;
            @(posedge clk);
            n++;
        end while (!rdy && n < 40);
        if (rdy) q32.push_back('{imm: {32'h0, imm}, instr: ins, ill: ill});
        else chk("send32_timeout", 64'd0, 64'd1);
        #1;
    endtask

    task automatic send64(input logic [31:0] ins, input logic [2:0] src,
                          input logic [63:0] imm);
        bit rdy;
        int n;
        b64.Instr   = ins;
        b64.ImmSrc  = src;
        b64.InValid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = b64.InReady;
            @(posedge clk);
            n++;
        end while (!rdy && n < 40);
        if (rdy) q64.push_back('{imm: imm, instr: ins, ill: 1'b0});
        else chk("send64_timeout", 64'd0, 64'd1);
        #1;
    endtask

    task automatic idle(input int cycles);
        b32.InValid = 1'b0;
        b64.InValid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    logic [31:0] v_instr [6];
    logic [2:0]  v_src   [6];
    logic [31:0] v_imm   [6];

    initial begin
        checks = 0;
        errors = 0;
        v_instr = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3,
                    32'h123452B7, 32'h0080006F, 32'h3400D073};
        v_src   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        v_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                    32'h12345000, 32'h00000008, 32'h00000001};

        rst_n = 1'b0;
        b32.Flush = 1'b0; b32.InValid = 1'b0; b32.Instr = '0; b32.ImmSrc = '0; b32.OutReady = 1'b0;
        b64.Flush = 1'b0; b64.InValid = 1'b0; b64.Instr = '0; b64.ImmSrc = '0; b64.OutReady = 1'b1;

        #3;
        chk("rst_outvalid", {63'h0, b32.OutValid}, 64'd0);
        chk("rst_count",    {62'h0, b32.Count}, 64'd0);
        chk("rst_inready",  {63'h0, b32.InReady}, 64'd1);
        chk("rst_immext",   {32'h0, b32.ImmExt}, 64'd0);
        chk("rst_illegal",  {63'h0, b32.IllegalImm}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back formats: push and pop coincide, occupancy stays at 1.
        b32.OutReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send32(v_instr[i], v_src[i], v_imm[i], 1'b0);
            chk("count_stream", {62'h0, b32.Count}, 64'd1);
        end
        idle(3);
        chk("count_drained", {62'h0, b32.Count}, 64'd0);

        send64(32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF);
        send64(32'h800002B7, 3'b011, 64'hFFFFFFFF80000000);
        send64(32'h3400D073, 3'b101, 64'h0000000000000001);
        idle(3);

        // Backpressure: A, B fill both entries; C waits until a slot frees.
        b32.OutReady = 1'b0;
        send32(32'h00100093, 3'b000, 32'h00000001, 1'b0);
        send32(32'h00200093, 3'b000, 32'h00000002, 1'b0);
        fork
            send32(32'h00300093, 3'b000, 32'h00000003, 1'b0);
            begin
                @(negedge clk);
                chk("bp_count",    {62'h0, b32.Count}, 64'd2);
                chk("bp_inready",  {63'h0, b32.InReady}, 64'd0);
                chk("bp_outvalid", {63'h0, b32.OutValid}, 64'd1);
                chk("bp_hold_a",   {32'h0, b32.ImmExt}, 64'd1);
                @(negedge clk);
                chk("bp_hold_a2",  {32'h0, b32.ImmExt}, 64'd1);
                @(posedge clk);
                #1 b32.OutReady = 1'b1;
            end
        join
        idle(4);
        chk("bp_count_end", {62'h0, b32.Count}, 64'd0);

        // Flush with both entries full and a beat offered in the same cycle.
        b32.OutReady = 1'b0;
        send32(32'h00400093, 3'b000, 32'h00000004, 1'b0);
        send32(32'h00500093, 3'b000, 32'h00000005, 1'b0);
        b32.Instr   = 32'h00600093;
        b32.ImmSrc  = 3'b000;
        b32.InValid = 1'b1;
        b32.OutReady = 1'b1;
        b32.Flush   = 1'b1;
        @(posedge clk);
        q32.delete();
        #1;
        b32.Flush   = 1'b0;
        b32.InValid = 1'b0;
        chk("fl_count",    {62'h0, b32.Count}, 64'd0);
        chk("fl_outvalid", {63'h0, b32.OutValid}, 64'd0);
        chk("fl_inready",  {63'h0, b32.InReady}, 64'd1);
        idle(4);

        // Reserved format, held, then asynchronous reset in mid-cycle.
        b32.OutReady = 1'b0;
        send32(32'hFFF00093, 3'b110, 32'hFFFFFFFF, 1'b1);
        b32.InValid = 1'b0;
        @(negedge clk);
        chk("rsv_imm",     {32'h0, b32.ImmExt}, 64'h00000000FFFFFFFF);
        chk("rsv_illegal", {63'h0, b32.IllegalImm}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        q32.delete();
        q64.delete();
        chk("arst_outvalid", {63'h0, b32.OutValid}, 64'd0);
        chk("arst_immext",   {32'h0, b32.ImmExt}, 64'd0);
        chk("arst_instrout", {32'h0, b32.InstrOut}, 64'd0);
        chk("arst_illegal",  {63'h0, b32.IllegalImm}, 64'd0);
        chk("arst_count",    {62'h0, b32.Count}, 64'd0);
        chk("arst_inready",  {63'h0, b32.InReady}, 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // First beat after reset is accepted on the first rising edge.
        b32.OutReady = 1'b1;
        send32(32'hFE112E23, 3'b001, 32'hFFFFFFFC, 1'b0);
        chk("post_rst_valid", {63'h0, b32.OutValid}, 64'd1);
        idle(4);

        chk("sb32_empty", 64'(q32.size()), 64'd0);
        chk("sb64_empty", 64'(q64.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
